// File: rtl/gen_io_pkg.sv
// Shared definitions for the multitap port logic: FSM states, header and type nibbles,
// and the bit positions of each button within a pad's 12-bit input group.
package gen_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int IDX_W   = 5;
    localparam int HDR_LEN = 3;
    localparam logic [IDX_W-1:0] IDX_MAX = 5'd31;

    localparam logic [3:0] NIB_IDLE = 4'h3;
    localparam logic [3:0] NIB_HDR0 = 4'hF;
    localparam logic [3:0] NIB_HDR1 = 4'h0;
    localparam logic [3:0] NIB_HDR2 = 4'h0;
    localparam logic [3:0] NIB_END  = 4'hF;

    localparam logic [3:0] TYPE_3BTN = 4'h0;
    localparam logic [3:0] TYPE_6BTN = 4'h1;
    localparam logic [3:0] TYPE_NONE = 4'hF;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    function automatic logic [3:0] type_code(input logic en, input logic six);
        if (!en)
            return TYPE_NONE;
        return six ? TYPE_6BTN : TYPE_3BTN;
    endfunction

endpackage

// File: rtl/gen_multitap_nib.sv
// Combinational nibble generator: maps a transfer index plus the latched pad types and
// the live button inputs to the 4-bit value the host reads at that index.
module gen_multitap_nib
    import gen_io_pkg::*;
#(
    parameter int NPADS = 4
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic [NPADS-1:0]    pad_6btn,
    input  logic [NPADS-1:0]    pad_en,
    input  logic [12*NPADS-1:0] pad_btn,
    output logic [3:0]          nib
);

    logic [5:0]  idx_w;
    logic [5:0]  base;
    logic [11:0] b;

    assign idx_w = {1'b0, idx};

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        nib  = NIB_END;
        base = 6'(HDR_LEN + NPADS);
        b    = '0;
        case (idx_w)
            6'd0: nib = NIB_HDR0;
            6'd1: nib = NIB_HDR1;
            6'd2: nib = NIB_HDR2;
            default: begin
                for (int p = 0; p < NPADS; p++) begin
                    if (idx_w == 6'(HDR_LEN + p))
                        nib = type_code(pad_en[p], pad_6btn[p]);
                end
                // Data nibbles are packed back to back; absent pads contribute nothing.
                for (int p = 0; p < NPADS; p++) begin
                    if (pad_en[p]) begin
                        b = pad_btn[12*p +: 12];
                        if (idx_w == base)
                            nib = ~{b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
                        else if (idx_w == base + 6'd1)
                            nib = ~{b[BTN_START], b[BTN_A], b[BTN_C], b[BTN_B]};
                        else if (pad_6btn[p] && idx_w == base + 6'd2)
                            nib = ~{b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
                        base = base + (pad_6btn[p] ? 6'd3 : 6'd2);
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/gen_multitap.sv
// Multitap adapter: serves up to four pads on one port through a TH/TR handshake.
// Optional watchdog enabled with `define GEN_MULTITAP_WATCHDOG_EN (timeout TMO CE ticks).
module gen_multitap
    import gen_io_pkg::*;
#(
    parameter int NPADS = 4,
    parameter int TMO   = 12000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                CE,
    input  logic [12*NPADS-1:0] PAD_BTN,
    input  logic [NPADS-1:0]    PAD_6BTN,
    input  logic [NPADS-1:0]    PAD_EN,
    input  logic                TH_IN,
    input  logic                TR_IN,
    output logic [7:0]          DO
);

    localparam logic [IDX_W-1:0] XFER_IDX = IDX_W'(HDR_LEN + NPADS);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [3:0]       nib_q, nib_d, data_nib;
    logic             tl_q, tl_d;
    logic             th_q, tr_q, seen_q;
    logic [NPADS-1:0] six_q, six_d, en_q, en_d;
    logic             th_fall, th_rise, tr_edge, wd_expire;

    // A falling TH is only trusted once TH has been sampled at least once after reset.
    assign th_fall = seen_q & th_q & ~TH_IN;
    assign th_rise = ~th_q & TH_IN;
    assign tr_edge = tr_q ^ TR_IN;
    assign idx_inc = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_W'(1);

    gen_multitap_nib #(.NPADS(NPADS)) u_nib (
        .idx      (idx_inc),
        .pad_6btn (six_q),
        .pad_en   (en_q),
        .pad_btn  (PAD_BTN),
        .nib      (data_nib)
    );

`ifdef GEN_MULTITAP_WATCHDOG_EN
    localparam int WD_W = $clog2(TMO + 1);
    logic [WD_W-1:0] wd_q;

    assign wd_expire = (wd_q == WD_W'(TMO - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            wd_q <= '0;
        else if (CE) begin
            if ((th_q ^ TH_IN) || tr_edge || state_q == IDLE || wd_expire)
                wd_q <= '0;
            else
                wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nib_d   = nib_q;
        tl_d    = tl_q;
        six_d   = six_q;
        en_d    = en_q;
        if (th_rise) begin
            state_d = IDLE;
            idx_d   = '0;
            tl_d    = 1'b1;
            nib_d   = NIB_IDLE;
        end else if (th_fall) begin
            state_d = HDR;
            idx_d   = '0;
            tl_d    = 1'b1;
            nib_d   = NIB_HDR0;
            six_d   = PAD_6BTN;
            en_d    = PAD_EN;
        end else if (state_q != IDLE) begin
            if (tr_edge) begin
                idx_d   = idx_inc;
                tl_d    = TR_IN;
                nib_d   = data_nib;
                state_d = (idx_inc >= XFER_IDX) ? XFER : HDR;
            end else if (wd_expire) begin
                state_d = IDLE;
                idx_d   = '0;
                tl_d    = 1'b1;
                nib_d   = NIB_IDLE;
            end
        end else begin
            idx_d = '0;
            tl_d  = 1'b1;
            nib_d = NIB_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            nib_q   <= NIB_IDLE;
            tl_q    <= 1'b1;
            th_q    <= 1'b1;
            tr_q    <= 1'b1;
            seen_q  <= 1'b0;
            six_q   <= '0;
            en_q    <= '0;
        end else if (CE) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            tl_q    <= tl_d;
            th_q    <= TH_IN;
            tr_q    <= TR_IN;
            seen_q  <= 1'b1;
            six_q   <= six_d;
            en_q    <= en_d;
        end
    end

    assign DO = {1'b0, th_q, tr_q, tl_q, nib_q};

endmodule

// File: tb/tb_gen_multitap.sv
// Directed bench for gen_multitap: a 4-pad and a 2-pad instance share the TH/TR/CE lines.
// Expected DO values are hand-computed as {0,TH,TR,TL,nibble}.
module tb_gen_multitap;
    import gen_io_pkg::*;

    typedef struct {
        logic       th;
        logic       tr;
        logic [7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        th, tr;
    logic [47:0] btn4;
    logic [3:0]  six4, en4;
    logic [7:0]  do4;
    logic [23:0] btn2;
    logic [1:0]  six2, en2;
    logic [7:0]  do2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vec_a [15];

    always #5 clk = ~clk;

    gen_multitap #(.NPADS(4), .TMO(16)) dut4 (
        .CLK(clk), .RESET_N(reset_n), .CE(ce), .PAD_BTN(btn4), .PAD_6BTN(six4),
        .PAD_EN(en4), .TH_IN(th), .TR_IN(tr), .DO(do4)
    );

    gen_multitap #(.NPADS(2), .TMO(16)) dut2 (
        .CLK(clk), .RESET_N(reset_n), .CE(ce), .PAD_BTN(btn2), .PAD_6BTN(six2),
        .PAD_EN(en2), .TH_IN(th), .TR_IN(tr), .DO(do2)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: DO=%02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic apply(input logic th_v, input logic tr_v);
        th = th_v;
        tr = tr_v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_nib_b(input int i);
        case (i)
            1, 2:    return 4'h0;
            3:       return 4'h1;
            7:       return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    initial begin
        logic       tr_v;
        logic [7:0] e;

        // 4 pads, all 3-button, pad0 A held: index 0..12 then a quiet tick then TH high
        vec_a[0]  = '{1'b0, 1'b1, 8'h3F};
        vec_a[1]  = '{1'b0, 1'b0, 8'h00};
        vec_a[2]  = '{1'b0, 1'b1, 8'h30};
        vec_a[3]  = '{1'b0, 1'b0, 8'h00};
        vec_a[4]  = '{1'b0, 1'b1, 8'h30};
        vec_a[5]  = '{1'b0, 1'b0, 8'h00};
        vec_a[6]  = '{1'b0, 1'b1, 8'h30};
        vec_a[7]  = '{1'b0, 1'b0, 8'h0F};
        vec_a[8]  = '{1'b0, 1'b1, 8'h3B};
        vec_a[9]  = '{1'b0, 1'b0, 8'h0F};
        vec_a[10] = '{1'b0, 1'b1, 8'h3F};
        vec_a[11] = '{1'b0, 1'b0, 8'h0F};
        vec_a[12] = '{1'b0, 1'b1, 8'h3F};
        vec_a[13] = '{1'b0, 1'b1, 8'h3F};
        vec_a[14] = '{1'b1, 1'b1, 8'h73};

        reset_n = 1'b0;
        ce      = 1'b1;
        th      = 1'b1;
        tr      = 1'b1;
        btn4    = 48'h0000_0000_0010;
        six4    = 4'b0000;
        en4     = 4'b1111;
        btn2    = 24'h00_0800;
        six2    = 2'b01;
        en2     = 2'b01;

        repeat (2) @(posedge clk);
        #1;
        check("reset_do4", do4, 8'h73);
        check("reset_do2", do2, 8'h73);
        reset_n = 1'b1;
        repeat (3) apply(1'b1, 1'b1);
        check("idle_do4", do4, 8'h73);
        check("idle_do2", do2, 8'h73);

        for (int i = 0; i < 15; i++) begin
            apply(vec_a[i].th, vec_a[i].tr);
            check($sformatf("seq4_step%0d", i), do4, vec_a[i].exp);
        end

        // 2 pads: 6-button pad0 with Z held, pad1 absent; index runs past saturation
        apply(1'b0, 1'b1);
        check("seq2_fall", do2, 8'h3F);
        six2 = 2'b00;
        tr_v = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tr_v = ~tr_v;
            apply(1'b0, tr_v);
            e = {1'b0, 1'b0, tr_v, tr_v, exp_nib_b(i)};
            check($sformatf("seq2_idx%0d", i), do2, e);
        end
        six2 = 2'b01;
        apply(1'b1, tr_v);
        check("seq2_exit", do2, 8'h73);

        // TH rises mid-transfer, then a new transfer restarts from index 0
        apply(1'b1, 1'b0);
        apply(1'b0, 1'b0);
        check("abort_fall", do4, 8'h1F);
        tr_v = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tr_v = ~tr_v;
            apply(1'b0, tr_v);
        end
        check("abort_idx5", do4, 8'h30);
        apply(1'b1, 1'b1);
        check("abort_idle", do4, 8'h73);
        apply(1'b0, 1'b1);
        check("restart_fall", do4, 8'h3F);
        tr_v = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tr_v = ~tr_v;
            apply(1'b0, tr_v);
            if (i == 7) check("restart_idx7", do4, 8'h0F);
            if (i == 8) check("restart_idx8", do4, 8'h3B);
        end
        apply(1'b1, 1'b1);

        // CE gating, then TH and TR edges on the same tick
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        check("ce_pre", do4, 8'h00);
        ce = 1'b0;
        apply(1'b0, 1'b1);
        check("ce_hold", do4, 8'h00);
        ce = 1'b1;
        apply(1'b0, 1'b1);
        check("ce_resume", do4, 8'h30);
        apply(1'b1, 1'b0);
        check("th_tr_same_tick", do4, 8'h53);
        apply(1'b1, 1'b1);

        // Stall with TH low and no TR edges
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        check("wd_start", do4, 8'h00);
        repeat (15) apply(1'b0, 1'b0);
        check("wd_tick15", do4, 8'h00);
        apply(1'b0, 1'b0);
`ifdef GEN_MULTITAP_WATCHDOG_EN
        check("wd_tick16", do4, 8'h13);
`else
        check("wd_tick16", do4, 8'h00);
`endif
        apply(1'b1, 1'b1);

        // Asynchronous reset mid-transfer; TH still low after release must not start one
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b0);
        check("rst_mid_pre", do4, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", do4, 8'h73);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(1'b0, 1'b0);
        check("rst_th_low", do4, 8'h13);
        apply(1'b0, 1'b1);
        check("rst_no_xfer", do4, 8'h33);
        apply(1'b1, 1'b1);
        check("rst_idle", do4, 8'h73);
        apply(1'b0, 1'b1);
        check("rst_fresh_fall", do4, 8'h3F);
        apply(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_multitap.md
GEN_MULTITAP -- requirements
Module: gen_multitap

Interface
REQ-001 Parameter NPADS, default 4, number of pads multiplexed on one port (legal range 1..4).
REQ-002 Parameter TMO, default 12000, watchdog timeout in CE ticks.
REQ-003 CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 CE  input  1  clock enable; all state advances occur only on cycles where CE=1.
REQ-006 PAD_BTN  input  12*NPADS  per pad {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}, active-high, pad 0 in the LSBs.
REQ-007 PAD_6BTN  input  NPADS  per pad: 1 = 6-button pad, 0 = 3-button pad.
REQ-008 PAD_EN  input  NPADS  per pad: 1 = connected, 0 = absent.
REQ-009 TH_IN  input  1  host TH line, already resolved from the port's CTL and DATA registers.
REQ-010 TR_IN  input  1  host TR line, already resolved from the port's CTL and DATA registers.
REQ-011 DO  output  8  registered port read value {0,TH,TR,TL,D3,D2,D1,D0}.

Function
REQ-012 FSM states: IDLE, HDR, XFER.
- IDLE: TH_IN=1.
- HDR and XFER: TH_IN=0.
REQ-013 In every state, DO[6] and DO[5] SHALL echo TH_IN and TR_IN, registered on CE.
REQ-014 IDLE: DO[4]=1 and DO[3:0]=4'h3.
REQ-015 On a TH_IN 1->0 edge, the FSM SHALL enter HDR with index=0 and DO[3:0]=4'hF.
REQ-016 Each TR_IN edge (either polarity) seen on CE while in HDR or XFER SHALL:
- increment the 5-bit index;
- set DO[4] equal to TR_IN on the same CE tick (1-tick acknowledge latency).
REQ-017 Nibble sequence by index:
- 0..2: 4'hF, 4'h0, 4'h0.
- 3..(2+NPADS), one nibble per pad: 4'h0 for a 3-button pad, 4'h1 for a 6-button pad, 4'hF for an absent pad.
- Then data, for present pads only, in pad order:
  - 3-button pads: {R,L,D,U}, then {START,A,C,B}.
  - 6-button pads additionally: {MODE,X,Y,Z}.
REQ-018 Data bits SHALL be active-low: pressed = 0.
REQ-019 The FSM SHALL move HDR->XFER once the index passes the type nibbles.
REQ-020 After the last data nibble, DO[3:0] SHALL read 4'hF.
REQ-021 The index SHALL saturate at 31; further TR edges keep toggling TL but return 4'hF.
REQ-022 A TH_IN 0->1 edge in any state SHALL return the FSM to IDLE on the same CE tick and discard the index.
REQ-023 If TH and TR edges occur on the same CE tick, the TH edge wins; the TR edge is ignored.
REQ-024 PAD_6BTN and PAD_EN SHALL be sampled at the TH 1->0 edge and held constant until IDLE.
REQ-025 Button inputs SHALL be sampled when the nibble that carries them is generated.

Reset
REQ-026 While RESET_N=0: FSM=IDLE, index=0, TL=1, DO=8'h73, watchdog counter=0.
REQ-027 Reset asserted mid-transfer SHALL abort asynchronously; the first transfer after release begins only on a fresh TH 1->0 edge.

Configuration
REQ-028 Macro GEN_MULTITAP_WATCHDOG_EN.
- Defined: a counter SHALL clear on every TH or TR edge and increment on CE in HDR/XFER. On reaching TMO, the FSM SHALL return to IDLE (DO[3:0]=4'h3, TL=1) until the next TH 1->0 edge.
- Undefined: no counter; only a TH edge or reset leaves HDR/XFER.

Structure
REQ-029 Shared package gen_io_pkg SHALL hold:
- the FSM state enum;
- the header nibble constants;
- the pad type codes (TYPE_3BTN=4'h0, TYPE_6BTN=4'h1, TYPE_NONE=4'hF);
- the button bit-index constants.
REQ-030 One sub-module, gen_multitap_nib, SHALL be purely combinational: index, sampled types and buttons -> nibble.

Verification
REQ-031 Reset: RESET_N=0 with TH_IN=1 -> DO=8'h73; after release with no stimulus, DO stays 8'h73.
REQ-032 NPADS=4, all pads 3-button, pad0 A held: TH 1->0, then 12 TR toggles.
- Nibbles: F,0,0,0,0,0,0,F(data pad0 D-pad),B(pad0 START/A/C/B),F,F,F.
- TL equals TR one CE tick after each edge.
REQ-033 NPADS=2, pad0 6-button with Z held, pad1 absent: header F,0,0,1,F; then F,F,E; then F for all further TR edges.
REQ-034 TH 0->1 issued after 5 TR edges -> DO=8'h73 on the next CE. A new TH 1->0 edge -> DO[3:0]=F with index restarted at 0.
REQ-035 Simultaneous TH 0->1 and TR edge on one CE tick -> IDLE; TL=1, not the TR value.
REQ-036 With GEN_MULTITAP_WATCHDOG_EN and TMO=16: TH low, then 16 CE ticks with no TR edge -> DO[3:0]=3, TL=1. Without the macro -> the previous nibble is held.
